pps_generator: RTL and testbench
================================

// Module: pps_generator
// PURPOSE
//  Local 1PPS/1 kHz timebase transmitter, the send side of pps_receiver. Divides ptp_clk to drive
//  a 1PPS pulse and a 1 kHz tick onto board pins/fabric, and counts seconds.
//  Software/PTP servo sets phase and seconds through a valid/ready adjust port.
// PARAMETERS
//  C_CLOCK_FREQUENCY  25000000  ptp_clk frequency in Hz (F); must be divisible by C_TICK_HZ
//  C_TICK_HZ          1000      ts_out rate in Hz; T = F/C_TICK_HZ cycles per tick
//  C_PULSE_WIDTH_MS   100       pps_out high time in ms; PW = C_PULSE_WIDTH_MS*(F/1000) cycles, PW < F
// PORTS
//  ptp_clk     in   1   core clock, all logic on rising edge
//  rst         in   1   reset, synchronous, active-high
//  enable      in   1   1 = counters run and outputs drive; 0 = freeze
//  adj_valid   in   1   adjust request
//  adj_ready   out  1   adjust accept (transfer on adj_valid && adj_ready)
//  adj_tick    in   W   tick index within second, W = $clog2(C_TICK_HZ)
//  adj_sec     in   32  seconds value to load
//  pps_out     out  1   1PPS pulse, PW cycles high
//  ts_out      out  1   1-cycle tick at C_TICK_HZ
//  sec_count   out  32  seconds counter
// BEHAVIOUR
//  - Counters: cnt 0..F-1 (cycles in second), sub 0..T-1 (cycles in tick), sec_count 32b.
//  - States: IDLE, RUN, LOAD. Reset -> IDLE; cnt=0, sub=0, sec_count=0, pps_out=0, ts_out=0.
//  - IDLE: counters hold. enable=1 -> RUN (counters resume from held values).
//  - RUN: each cycle sub+1 (T-1 -> 0), cnt+1 (F-1 -> 0); on cnt F-1 -> 0, sub forced 0 and
//    sec_count+1 (0xFFFFFFFF wraps to 0). enable=0 -> IDLE, counters freeze at current values.
//  - adj_ready = (state != LOAD); high out of reset. adj_valid ignored while rst=1.
//  - Accept (RUN or IDLE): at that edge cnt <= min(adj_tick, C_TICK_HZ-1)*T, sub <= 0,
//    sec_count <= adj_sec, state -> LOAD. Accept overrides a same-cycle wrap (no sec increment).
//  - LOAD: exactly 1 cycle, counters hold, adj_ready=0; next -> RUN if enable else IDLE.
//  - Outputs registered, 1-cycle latency from counter state:
//    pps_out <= (state==RUN) && (cnt < PW);  ts_out <= (state==RUN) && (sub == 0).
//    Thus cycle with cnt=0 in RUN -> pps_out rises next cycle, high PW cycles; ts_out coincides.
//  - Leaving RUN (enable=0, accept, rst) forces pps_out/ts_out low on next cycle; a
//    truncated pulse is not extended. Pulse re-asserts only if cnt < PW when RUN resumes.
//  - rst mid-pulse or mid-LOAD: all state returns to reset values on the next edge.
//  - sec_count updates visible the cycle after the wrap edge, same cycle pps_out rises.
// TESTING (F=10000, C_TICK_HZ=1000 -> T=10, C_PULSE_WIDTH_MS=100 -> PW=1000)
//  1 rst then enable=1 at cycle 0 -> pps_out high cycles 1..1000; ts_out at 1,11,21,..;
//    pps_out rises again at 10001 with sec_count=1.
//  2 enable=0 at cnt=500 for 50 cycles -> outputs 0 next cycle, sec/cnt frozen; re-enable ->
//    pps_out high for remaining 500 cycles, next rise 9500 cycles after resume.
//  3 in RUN accept adj_tick=999, adj_sec=41 -> after LOAD, cnt=9990; 10 RUN cycles later
//    sec_count=42 and pps_out rises; ts_out 1 cycle after LOAD exit.
//  4 adj_tick=1023 (>999) -> clamped, cnt loaded 9990, same result as scenario 3.
//  5 adj_valid held 3 cycles, changing data -> accepts on cycles 0 and 2, adj_ready=0 on 1;
//    accept coinciding with cnt=F-1 -> sec_count=adj_sec, no increment.
//  6 rst pulse during pps high (cnt=300) -> next cycle pps_out=0, ts_out=0, sec_count=0,
//    adj_ready=1, state IDLE; enable -> pps_out rises 1 cycle after first RUN cycle.

Source files
------------

// File: rtl/pps_generator.sv
// Local 1PPS / tick timebase: divides ptp_clk into a seconds pulse, a per-tick strobe
// and a running seconds count, with a valid/ready port to load phase and seconds.
module pps_generator #(
    parameter int unsigned C_CLOCK_FREQUENCY = 25000000,
    parameter int unsigned C_TICK_HZ         = 1000,
    parameter int unsigned C_PULSE_WIDTH_MS  = 100,
    localparam int unsigned W = (C_TICK_HZ > 1) ? $clog2(C_TICK_HZ) : 1
) (
    input  logic         ptp_clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         adj_valid,
    output logic         adj_ready,
    input  logic [W-1:0] adj_tick,
    input  logic [31:0]  adj_sec,
    output logic         pps_out,
    output logic         ts_out,
    output logic [31:0]  sec_count
);

    localparam int unsigned T_CYC  = C_CLOCK_FREQUENCY / C_TICK_HZ;
    localparam int unsigned PW_CYC = C_PULSE_WIDTH_MS * (C_CLOCK_FREQUENCY / 1000);
    localparam int unsigned CW     = (C_CLOCK_FREQUENCY > 1) ? $clog2(C_CLOCK_FREQUENCY) : 1;
    localparam int unsigned SW     = (T_CYC > 1) ? $clog2(T_CYC) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(C_CLOCK_FREQUENCY - 1);
    localparam logic [CW-1:0] CNT_PW   = CW'(PW_CYC);
    localparam logic [SW-1:0] SUB_MAX  = SW'(T_CYC - 1);
    localparam logic [W-1:0]  TICK_MAX = W'(C_TICK_HZ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] sub_q;
    logic [31:0]   sec_q;
    logic [31:0]   sec_out_q;
    logic          pps_q;
    logic          ts_q;

    logic          accept;
    logic [W-1:0]  tick_clamp_d;
    logic [CW-1:0] cnt_load_d;

    assign adj_ready = (state_q != ST_LOAD);
    assign accept    = adj_valid && adj_ready;

    // Out-of-range tick indices clamp to the last tick of the second.
    always_comb begin
        tick_clamp_d = (adj_tick > TICK_MAX) ? TICK_MAX : adj_tick;
        cnt_load_d   = CW'(32'(tick_clamp_d) * T_CYC);
    end

    always_ff @(posedge ptp_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sub_q     <= '0;
            sec_q     <= '0;
            sec_out_q <= '0;
            pps_q     <= 1'b0;
            ts_q      <= 1'b0;
        end else begin
            // Outputs drop whenever this cycle is not a counting RUN cycle.
            pps_q     <= 1'b0;
            ts_q      <= 1'b0;
            sec_out_q <= sec_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q   <= cnt_load_d;
                        sub_q   <= '0;
                        sec_q   <= adj_sec;
                        state_q <= ST_LOAD;
                    end else if (enable) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_q   <= cnt_load_d;
                        sub_q   <= '0;
                        sec_q   <= adj_sec;
                        state_q <= ST_LOAD;
                    end else if (!enable) begin
                        state_q <= ST_IDLE;
                    end else begin
                        pps_q <= (cnt_q < CNT_PW);
                        ts_q  <= (sub_q == '0);
                        if (cnt_q == CNT_MAX) begin
                            cnt_q <= '0;
                            sub_q <= '0;
                            sec_q <= sec_q + 32'd1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            sub_q <= (sub_q == SUB_MAX) ? '0 : sub_q + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q <= enable ? ST_RUN : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pps_out   = pps_q;
    assign ts_out    = ts_q;
    assign sec_count = sec_out_q;

endmodule

// File: tb/tb_pps_generator.sv
// Directed bench for pps_generator at F=10000, 1 kHz ticks, 100 ms pulse (T=10, PW=1000).
module tb_pps_generator;

    logic        ptp_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        adj_valid;
    logic        adj_ready;
    logic [9:0]  adj_tick;
    logic [31:0] adj_sec;
    logic        pps_out;
    logic        ts_out;
    logic [31:0] sec_count;

    int errors = 0;
    int checks = 0;

    always #5 ptp_clk = ~ptp_clk;

    pps_generator #(
        .C_CLOCK_FREQUENCY(10000),
        .C_TICK_HZ        (1000),
        .C_PULSE_WIDTH_MS (100)
    ) dut (
        .ptp_clk  (ptp_clk),
        .rst      (rst),
        .enable   (enable),
        .adj_valid(adj_valid),
        .adj_ready(adj_ready),
        .adj_tick (adj_tick),
        .adj_sec  (adj_sec),
        .pps_out  (pps_out),
        .ts_out   (ts_out),
        .sec_count(sec_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ptp_clk);
        #1;
    endtask

    // Accept one adjust while RUN, then watch pps/ts over the 15 cycles after the accept edge.
    task automatic adjust_watch(input logic [9:0] t, input logic [31:0] s,
                                input logic [15:0] exp_pps, input logic [15:0] exp_ts,
                                input logic [31:0] exp_sec, input string tag);
        logic [15:0] pps_seen;
        logic [15:0] ts_seen;
        pps_seen = '0;
        ts_seen  = '0;
        check({tag, "_ready_pre"}, adj_ready, 1);
        adj_valid = 1'b1;
        adj_tick  = t;
        adj_sec   = s;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (j == 1) begin
                adj_valid = 1'b0;
                check({tag, "_ready_load"}, adj_ready, 0);
            end
            if (j == 2) check({tag, "_sec_loaded"}, sec_count, s);
            pps_seen[j] = pps_out;
            ts_seen[j]  = ts_out;
        end
        check({tag, "_pps_mask"}, pps_seen, exp_pps);
        check({tag, "_ts_mask"}, ts_seen, exp_ts);
        check({tag, "_sec_end"}, sec_count, exp_sec);
        $display("adjust %s: tick=%0d sec=%0d pps=%h ts=%h sec_end=%0d",
                 tag, t, s, pps_seen, ts_seen, sec_count);
    endtask

    initial begin
        int          bad;
        logic        exp_p;
        logic        exp_t;
        logic [31:0] sec_a;
        logic [31:0] sec_b;

        rst       = 1'b1;
        enable    = 1'b0;
        adj_valid = 1'b0;
        adj_tick  = '0;
        adj_sec   = '0;
        tick();
        tick();
        check("rst_pps", pps_out, 0);
        check("rst_ts", ts_out, 0);
        check("rst_sec", sec_count, 0);
        check("rst_ready", adj_ready, 1);

        // 1: free run from reset
        rst = 1'b0;
        repeat (3) tick();
        check("s1_idle_pps", pps_out, 0);
        enable = 1'b1;
        tick();                                 // first RUN cycle, cnt=0
        check("s1_pps_c0", pps_out, 0);
        bad = 0; sec_a = '1; sec_b = '1;
        for (int c = 1; c <= 10001; c++) begin
            tick();
            exp_p = (c <= 1000) || (c == 10001);
            exp_t = ((c % 10) == 1);
            if (pps_out !== exp_p || ts_out !== exp_t) bad++;
            if (c == 10000) sec_a = sec_count;
            if (c == 10001) sec_b = sec_count;
        end
        check("s1_pattern_bad_cycles", bad, 0);
        check("s1_sec_before_rise", sec_a, 0);
        check("s1_sec_at_rise", sec_b, 1);
        $display("scenario 1: free run, bad cycles=%0d sec=%0d", bad, sec_b);

        // 2: freeze at cnt=500 for 50 cycles
        repeat (499) tick();                    // cnt=500
        check("s2_pps_before", pps_out, 1);
        enable = 1'b0;
        tick();
        check("s2_pps_off", pps_out, 0);
        check("s2_ts_off", ts_out, 0);
        repeat (49) tick();
        check("s2_pps_frozen", pps_out, 0);
        check("s2_sec_frozen", sec_count, 1);
        enable = 1'b1;
        tick();                                 // first RUN cycle after resume, cnt=500
        check("s2_pps_r0", pps_out, 0);
        bad = 0; sec_a = '1; sec_b = '1;
        for (int k = 1; k <= 9501; k++) begin
            tick();
            exp_p = (k <= 500) || (k == 9501);
            exp_t = ((k % 10) == 1);
            if (pps_out !== exp_p || ts_out !== exp_t) bad++;
            if (k == 9500) sec_a = sec_count;
            if (k == 9501) sec_b = sec_count;
        end
        check("s2_pattern_bad_cycles", bad, 0);
        check("s2_sec_before_rise", sec_a, 1);
        check("s2_sec_at_rise", sec_b, 2);
        $display("scenario 2: freeze/resume, bad cycles=%0d sec=%0d", bad, sec_b);

        // 3/4: last tick of second, direct and clamped; then a tick leaving 10 pulse cycles
        adjust_watch(10'd999,  32'd41,  16'hE000, 16'h2008, 32'd42,  "s3_tick999");
        adjust_watch(10'd1023, 32'd100, 16'hE000, 16'h2008, 32'd101, "s4_tick1023");
        adjust_watch(10'd99,   32'd500, 16'h1FF8, 16'h2008, 32'd500, "s4b_tick99");

        // 5: valid held 3 cycles, first accept lands on cnt=F-1
        repeat (8996) tick();                   // cnt=9999
        adj_valid = 1'b1;
        adj_tick  = 10'd0;
        adj_sec   = 32'd7;
        check("s5_ready_c0", adj_ready, 1);
        tick();
        check("s5_ready_c1", adj_ready, 0);
        adj_tick = 10'd500;
        adj_sec  = 32'd8;
        tick();
        check("s5_sec_c2", sec_count, 7);
        check("s5_ready_c2", adj_ready, 1);
        adj_tick = 10'd999;
        adj_sec  = 32'd9;
        tick();
        adj_valid = 1'b0;
        check("s5_ready_c3", adj_ready, 0);
        check("s5_pps_c3", pps_out, 0);
        tick();
        check("s5_sec_c4", sec_count, 9);
        repeat (11) tick();
        check("s5_pps_c15", pps_out, 1);
        check("s5_sec_c15", sec_count, 10);
        $display("scenario 5: back-to-back adjust, sec=%0d", sec_count);

        // 6: reset in the middle of a pulse, with adj_valid asserted alongside
        repeat (299) tick();                    // cnt=300
        check("s6_pps_before", pps_out, 1);
        rst       = 1'b1;
        adj_valid = 1'b1;
        adj_sec   = 32'd123;
        tick();
        rst       = 1'b0;
        adj_valid = 1'b0;
        check("s6_pps_rst", pps_out, 0);
        check("s6_ts_rst", ts_out, 0);
        check("s6_sec_rst", sec_count, 0);
        check("s6_ready_rst", adj_ready, 1);
        tick();                                 // first RUN cycle
        check("s6_pps_r2", pps_out, 0);
        tick();
        check("s6_pps_r3", pps_out, 1);
        check("s6_ts_r3", ts_out, 1);
        check("s6_sec_r3", sec_count, 0);
        repeat (999) tick();
        check("s6_pps_last", pps_out, 1);
        tick();
        check("s6_pps_end", pps_out, 0);
        $display("scenario 6: reset mid-pulse, sec=%0d", sec_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
